dmem_responder: RTL and testbench

//  Data-memory responder at the far end of the mem-stage load/store interface.

---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// word geometry and a small range-check helper.
package dmem_responder_pkg;

  localparam int DMEM_WORD_BYTES = 4;
  localparam int DMEM_DATA_W     = 32;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_WAIT = 2'd1,
    DMEM_ST_DONE = 2'd2
  } dmem_state_e;

  // True when a word index falls outside an array of the given depth.
  function automatic logic index_out_of_range(input logic [29:0] index,
                                              input int unsigned depth);
    return ({2'b00, index} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x 32, with a registered read port.
// Contents are intentionally never cleared by reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem_q [DEPTH];
  logic [DMEM_DATA_W-1:0] rdata_q;

  // Write-when-enabled and read-every-cycle on the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the mem-stage load/store interface.
// Each accepted request is held for WAIT_CYCLES wait states behind mem_stall,
// then performed on the array; loads return registered data, illegal
// accesses return zero and pulse mem_fault.
// Optional build macro DMEM_MISALIGN_TRAP_EN: when defined, a byte address
// that is not word aligned is treated as an illegal access.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_oe,
  input  logic                   mem_wr,
  input  logic [31:0]            mem_addr,
  input  logic [DMEM_DATA_W-1:0] mem_wdata,
  output logic [DMEM_DATA_W-1:0] mem_rdata,
  output logic                   mem_stall,
  output logic                   mem_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  dmem_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lat_load_q, lat_load_d;
  logic                   lat_illegal_q, lat_illegal_d;
  logic [AW-1:0]          lat_addr_q, lat_addr_d;
  logic [DMEM_DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic                   show_ram_q, show_ram_d;
  logic [DMEM_DATA_W-1:0] hold_q, hold_d;
  logic                   fault_q, fault_d;

  logic                   req;
  logic [29:0]            in_index;
  logic [AW-1:0]          in_addr;
  logic                   in_misalign;
  logic                   in_illegal;
  logic                   acc_now;
  logic                   acc_load;
  logic                   acc_illegal;
  logic [AW-1:0]          acc_addr;
  logic [DMEM_DATA_W-1:0] acc_wdata;
  logic                   ram_we;
  logic [DMEM_DATA_W-1:0] ram_rdata;

  assign req      = mem_oe | mem_wr;
  assign in_index = mem_addr[31:2];
  assign in_addr  = in_index[AW-1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign in_misalign = (mem_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^mem_addr[1:0];
  assign in_misalign      = 1'b0;
`endif

  assign in_illegal = (mem_oe & mem_wr) | index_out_of_range(in_index, DEPTH) | in_misalign;

  // Select which request hits the array this cycle: live inputs from IDLE, latched ones from WAIT.
  always_comb begin
    acc_now     = 1'b0;
    acc_load    = lat_load_q;
    acc_illegal = lat_illegal_q;
    acc_addr    = lat_addr_q;
    acc_wdata   = lat_wdata_q;
    if (state_q == DMEM_ST_IDLE) begin
      acc_load    = mem_oe;
      acc_illegal = in_illegal;
      acc_addr    = in_addr;
      acc_wdata   = mem_wdata;
      acc_now     = req && (WAIT_CYCLES == 0);
    end else if (state_q == DMEM_ST_WAIT) begin
      acc_now = (cnt_q == CW'(1));
    end
    if (rst) begin
      acc_now = 1'b0;
    end
  end

  assign ram_we = acc_now && !acc_load && !acc_illegal;

  // Next-state, counter, request latches and load-result bookkeeping.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_load_d    = lat_load_q;
    lat_illegal_d = lat_illegal_q;
    lat_addr_d    = lat_addr_q;
    lat_wdata_d   = lat_wdata_q;
    show_ram_d    = acc_now && acc_load && !acc_illegal;
    fault_d       = acc_now && acc_illegal;
    hold_d        = hold_q;
    if (acc_now && acc_illegal) begin
      hold_d = '0;
    end else if (show_ram_q) begin
      hold_d = ram_rdata;
    end
    case (state_q)
      DMEM_ST_IDLE: begin
        if (req && WAIT_CYCLES > 0) begin
          lat_load_d    = mem_oe;
          lat_illegal_d = in_illegal;
          lat_addr_d    = in_addr;
          lat_wdata_d   = mem_wdata;
          cnt_d         = CW'(WAIT_CYCLES);
          state_d       = DMEM_ST_WAIT;
        end
      end
      DMEM_ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DMEM_ST_DONE;
        end
      end
      DMEM_ST_DONE: state_d = DMEM_ST_IDLE;
      default:      state_d = DMEM_ST_IDLE;
    endcase
  end

  // State register with synchronous reset; aborting mid-access just returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DMEM_ST_IDLE;
      cnt_q         <= '0;
      lat_load_q    <= 1'b0;
      lat_illegal_q <= 1'b0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      show_ram_q    <= 1'b0;
      hold_q        <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_load_q    <= lat_load_d;
      lat_illegal_q <= lat_illegal_d;
      lat_addr_q    <= lat_addr_d;
      lat_wdata_q   <= lat_wdata_d;
      show_ram_q    <= show_ram_d;
      hold_q        <= hold_d;
      fault_q       <= fault_d;
    end
  end

  assign mem_stall = (state_q == DMEM_ST_WAIT) ||
                     ((state_q == DMEM_ST_IDLE) && req && (WAIT_CYCLES > 0));
  assign mem_rdata = show_ram_q ? ram_rdata : hold_q;
  assign mem_fault = fault_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven by directed and
// random accesses against a word-level reference memory, plus a
// single-cycle (WAIT_CYCLES=0) instance for back-to-back behaviour.
module tb_dmem_responder;

  localparam int DEPTH  = 1024;
  localparam int WAIT_A = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_oe, a_wr, a_stall, a_fault;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_oe, b_wr, b_stall, b_fault;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .rst(rst), .mem_oe(a_oe), .mem_wr(a_wr), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_stall(a_stall), .mem_fault(a_fault)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .mem_oe(b_oe), .mem_wr(b_wr), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_stall(b_stall), .mem_fault(b_fault)
  );

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Illegal-access rule stated directly on the byte address.
  function automatic bit refIllegal(input bit oe, input bit wr, input logic [31:0] addr);
    bit bad;
    bad = (oe && wr) || ((addr / 32'd4) >= 32'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
    bad = bad || ((addr % 32'd4) != 32'd0);
`endif
    return bad;
  endfunction

  // One full access on the waited instance; called and returns at 1ns after a rising edge.
  task automatic applyStimulus(input string tag, input bit oe, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int stall_cycles;
    bit exp_fault;
    int idx;
    idx       = int'(addr / 32'd4);
    exp_fault = refIllegal(oe, wr, addr);
    if (exp_fault)  ref_rdata = 32'd0;
    else if (oe)    ref_rdata = ref_mem[idx];
    else            ref_mem[idx] = wdata;
    a_oe = oe; a_wr = wr; a_addr = addr; a_wdata = wdata;
    stall_cycles = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!a_stall) break;
      stall_cycles++;
    end
    checkOutput({tag, " stall_cycles"}, 32'(stall_cycles), 32'(WAIT_A + 1));
    checkOutput({tag, " rdata"}, a_rdata, ref_rdata);
    checkOutput({tag, " fault"}, {31'd0, a_fault}, {31'd0, exp_fault});
    @(posedge clk); #1;
    a_oe = 1'b0; a_wr = 1'b0;
    @(negedge clk);
    checkOutput({tag, " after_stall"}, {31'd0, a_stall}, 32'd0);
    checkOutput({tag, " after_fault"}, {31'd0, a_fault}, 32'd0);
    checkOutput({tag, " after_rdata"}, a_rdata, ref_rdata);
    @(posedge clk); #1;
  endtask

  task automatic randomPhase();
    int kind;
    logic [31:0] base;
    logic [31:0] addr;
    bit op_load;
    for (int w = 0; w < 16; w++) begin
      applyStimulus("rnd_preload", 1'b0, 1'b1, 32'(w * 4), $urandom);
    end
    for (int i = 0; i < 40; i++) begin
      kind    = int'($urandom_range(0, 9));
      base    = 32'($urandom_range(0, 15)) * 32'd4;
      op_load = ($urandom_range(0, 1) == 1);
      if (kind <= 3) begin
        applyStimulus("rnd_load", 1'b1, 1'b0, base, 32'd0);
      end else if (kind <= 6) begin
        applyStimulus("rnd_store", 1'b0, 1'b1, base, $urandom);
      end else if (kind == 7) begin
        applyStimulus("rnd_both", 1'b1, 1'b1, base, $urandom);
      end else if (kind == 8) begin
        addr = 32'(DEPTH * 4) + ($urandom & 32'h0FFF_FFFC);
        applyStimulus("rnd_oor", op_load, !op_load, addr, $urandom);
      end else begin
        addr = base | 32'($urandom_range(1, 3));
        applyStimulus("rnd_misalign", op_load, !op_load, addr, $urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_oe = 1'b0; a_wr = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
    b_oe = 1'b0; b_wr = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    ref_rdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset a_stall", {31'd0, a_stall}, 32'd0);
    checkOutput("reset a_fault", {31'd0, a_fault}, 32'd0);
    checkOutput("reset a_rdata", a_rdata, 32'd0);
    checkOutput("reset b_stall", {31'd0, b_stall}, 32'd0);
    checkOutput("reset b_rdata", b_rdata, 32'd0);
    @(posedge clk); #1;

    // Single-cycle instance: preload 1 and 2, then back-to-back loads.
    b_wr = 1'b1; b_addr = 32'h0; b_wdata = 32'd1;
    @(negedge clk); checkOutput("b st0 stall", {31'd0, b_stall}, 32'd0);
    @(posedge clk); #1; b_addr = 32'h4; b_wdata = 32'd2;
    @(negedge clk); checkOutput("b st4 stall", {31'd0, b_stall}, 32'd0);
    @(posedge clk); #1; b_wr = 1'b0; b_oe = 1'b1; b_addr = 32'h0;
    @(negedge clk); checkOutput("b ld0 stall", {31'd0, b_stall}, 32'd0);
    @(posedge clk); #1; b_addr = 32'h4;
    @(negedge clk);
    checkOutput("b ld4 stall", {31'd0, b_stall}, 32'd0);
    checkOutput("b rdata first", b_rdata, 32'd1);
    @(posedge clk); #1; b_oe = 1'b0;
    @(negedge clk);
    checkOutput("b rdata second", b_rdata, 32'd2);
    checkOutput("b fault quiet", {31'd0, b_fault}, 32'd0);
    @(posedge clk); #1; b_oe = 1'b1; b_wr = 1'b1; b_addr = 32'h0;
    @(negedge clk); checkOutput("b both stall", {31'd0, b_stall}, 32'd0);
    @(posedge clk); #1; b_oe = 1'b0; b_wr = 1'b0;
    @(negedge clk);
    checkOutput("b both fault", {31'd0, b_fault}, 32'd1);
    checkOutput("b both rdata", b_rdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b fault pulse end", {31'd0, b_fault}, 32'd0);
    checkOutput("b rdata hold zero", b_rdata, 32'd0);
    @(posedge clk); #1;

    // Waited instance: directed cases.
    applyStimulus("st 0x0", 1'b0, 1'b1, 32'h0, 32'h1111_1111);
    applyStimulus("st 0x10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    applyStimulus("ld 0x10", 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus("st 0x20", 1'b0, 1'b1, 32'h20, 32'h5);
    applyStimulus("both 0x20", 1'b1, 1'b1, 32'h20, 32'h99);
    applyStimulus("ld 0x20", 1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus("st top", 1'b0, 1'b1, 32'((DEPTH - 1) * 4), 32'h77);
    applyStimulus("ld top", 1'b1, 1'b0, 32'((DEPTH - 1) * 4), 32'h0);
    applyStimulus("ld oor", 1'b1, 1'b0, 32'(DEPTH * 4), 32'h0);
    applyStimulus("st oor", 1'b0, 1'b1, 32'(DEPTH * 4), 32'hBAD);
    applyStimulus("ld 0x0 after oor", 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus("ld top after oor", 1'b1, 1'b0, 32'((DEPTH - 1) * 4), 32'h0);
    applyStimulus("ld far", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    applyStimulus("ld 0x13", 1'b1, 1'b0, 32'h13, 32'h0);

    // Reset in the last wait state of a store: the store must not land.
    applyStimulus("st 0x40 old", 1'b0, 1'b1, 32'h40, 32'hAAAA_5555);
    a_wr = 1'b1; a_addr = 32'h40; a_wdata = 32'h1234;
    @(posedge clk); #1;
    @(negedge clk); checkOutput("rst wait stall", {31'd0, a_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; a_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_rdata = 32'd0;
    @(negedge clk);
    checkOutput("rst abort stall", {31'd0, a_stall}, 32'd0);
    checkOutput("rst abort fault", {31'd0, a_fault}, 32'd0);
    checkOutput("rst abort rdata", a_rdata, 32'd0);
    @(posedge clk); #1;
    applyStimulus("ld 0x40 old", 1'b1, 1'b0, 32'h40, 32'h0);

    randomPhase();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
